// File: rtl/hms_time_counter.sv
// hms_time_counter: cascaded modulo time-of-day counter (seconds, minutes, hours).
// A 1 Hz tick advances the cascade up or down with carry/borrow between fields.
// A synchronous parallel load and a per-field manual adjust take priority over
// the tick. A registered day_wrap pulse flags a full-day rollover or underflow.
module hms_time_counter #(
    parameter int MOD_S = 60,
    parameter int MOD_M = 60,
    parameter int MOD_H = 24,
    parameter int WS    = 6,
    parameter int WM    = 6,
    parameter int WH    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          up_down,
    input  logic          load,
    input  logic [WS-1:0] load_s,
    input  logic [WM-1:0] load_m,
    input  logic [WH-1:0] load_h,
    input  logic          adj_en,
    input  logic [1:0]    adj_sel,
    input  logic          adj_step,
    output logic [WS-1:0] sec,
    output logic [WM-1:0] min,
    output logic [WH-1:0] hr,
    output logic          day_wrap
);

    // Largest legal value of each field.
    localparam logic [WS-1:0] S_MAX = WS'(MOD_S - 1);
    localparam logic [WM-1:0] M_MAX = WM'(MOD_M - 1);
    localparam logic [WH-1:0] H_MAX = WH'(MOD_H - 1);

    // Action selected for the current edge, in priority order.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_ADJUST,
        OP_TICK
    } op_t;

    op_t op;

    // Terminal-count detects for both directions.
    logic s_top, s_bot, m_top, m_bot, h_top, h_bot;
    logic s_term, m_term, h_term;
    logic m_step, h_step, wrap_all;

    // One-step advanced value of each field in the up_down direction.
    logic [WS-1:0] s_adv, s_ld;
    logic [WM-1:0] m_adv, m_ld;
    logic [WH-1:0] h_adv, h_ld;

    logic [WS-1:0] sec_n;
    logic [WM-1:0] min_n;
    logic [WH-1:0] hr_n;
    logic          wrap_n;

    // Decode the single action for this edge: load > adjust > tick > hold.
    always_comb begin
        op = OP_HOLD;
        if (load) begin
            op = OP_LOAD;
        end else if (adj_en) begin
            op = OP_ADJUST;
        end else if (tick) begin
            op = OP_TICK;
        end
    end

    // Per-field terminal detects and the combinational carry/borrow chain.
    always_comb begin
        s_top = (sec == S_MAX);
        s_bot = (sec == '0);
        m_top = (min == M_MAX);
        m_bot = (min == '0);
        h_top = (hr == H_MAX);
        h_bot = (hr == '0);

        s_term = up_down ? s_top : s_bot;
        m_term = up_down ? m_top : m_bot;
        h_term = up_down ? h_top : h_bot;

        // Whole cascade resolves in one edge: terminal counts ANDed up the chain.
        m_step   = s_term;
        h_step   = s_term & m_term;
        wrap_all = s_term & m_term & h_term;
    end

    // Modulo +/-1 of each field; shared by tick and adjust.
    always_comb begin
        if (up_down) begin
            s_adv = s_top ? '0 : sec + WS'(1);
            m_adv = m_top ? '0 : min + WM'(1);
            h_adv = h_top ? '0 : hr + WH'(1);
        end else begin
            s_adv = s_bot ? S_MAX : sec - WS'(1);
            m_adv = m_bot ? M_MAX : min - WM'(1);
            h_adv = h_bot ? H_MAX : hr - WH'(1);
        end
    end

    // Out-of-range load values are replaced by zero, field by field.
    always_comb begin
        s_ld = (load_s > S_MAX) ? '0 : load_s;
        m_ld = (load_m > M_MAX) ? '0 : load_m;
        h_ld = (load_h > H_MAX) ? '0 : load_h;
    end

    // Next-state selection for the three fields and the wrap pulse.
    always_comb begin
        sec_n  = sec;
        min_n  = min;
        hr_n   = hr;
        wrap_n = 1'b0;
        unique case (op)
            OP_LOAD: begin
                sec_n = s_ld;
                min_n = m_ld;
                hr_n  = h_ld;
            end
            OP_ADJUST: begin
                // Adjust steps only the selected field; no carry leaves it.
                if (adj_step) begin
                    case (adj_sel)
                        2'd0:    sec_n = s_adv;
                        2'd1:    min_n = m_adv;
                        2'd2:    hr_n  = h_adv;
                        default: ;
                    endcase
                end
            end
            OP_TICK: begin
                sec_n = s_adv;
                if (m_step) begin
                    min_n = m_adv;
                end
                if (h_step) begin
                    hr_n = h_adv;
                end
                wrap_n = wrap_all;
            end
            default: ;
        endcase
    end

    // Field and pulse registers; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec      <= '0;
            min      <= '0;
            hr       <= '0;
            day_wrap <= 1'b0;
        end else begin
            sec      <= sec_n;
            min      <= min_n;
            hr       <= hr_n;
            day_wrap <= wrap_n;
        end
    end

endmodule

// File: doc/hms_time_counter.md
Name: hms_time_counter

Overview:
- Cascaded, parametrised modulo time-of-day counter with three fields: seconds, minutes and hours.
- Replaces the single-field up/down counters in the alarm-clock datapath.
- Adds inter-field carry and borrow, a synchronous parallel load, per-field manual adjust without carry, and a day-wrap pulse.
- Driven by a 1 Hz tick enable from the clock divider. Outputs feed the display mux and the alarm comparator.

Parameters:
MOD_S, 60, seconds modulus; field counts 0..MOD_S-1
MOD_M, 60, minutes modulus
MOD_H, 24, hours modulus
WS, 6, seconds width; requires MOD_S <= 2**WS
WM, 6, minutes width; requires MOD_M <= 2**WM
WH, 5, hours width; requires MOD_H <= 2**WH

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high; clears all state
tick  in  1  one-cycle count enable (1 Hz strobe)
up_down  in  1  1 = count up, 0 = count down (applies to tick and adjust)
load  in  1  synchronous parallel load strobe
load_s  in  WS  seconds load value
load_m  in  WM  minutes load value
load_h  in  WH  hours load value
adj_en  in  1  adjust mode; freezes tick counting
adj_sel  in  2  0 = seconds, 1 = minutes, 2 = hours, 3 = none
adj_step  in  1  one-cycle strobe: step the selected field once in the up_down direction
sec  out  WS  seconds field, registered
min  out  WM  minutes field, registered
hr  out  WH  hours field, registered
day_wrap  out  1  registered one-cycle pulse on full-day rollover or underflow

Behaviour:
- Reset (async, active-high): sec = 0, min = 0, hr = 0, day_wrap = 0, immediately and held while reset is high. Reset mid-load or mid-adjust discards the pending operation.
- Per-edge priority: reset > load > adjust (adj_en = 1) > tick. Exactly one action per edge.
- Load:
  - sec/min/hr take load_s/load_m/load_h on the edge.
  - Any field value >= its modulus loads as 0; other fields are unaffected.
  - day_wrap = 0.
- Adjust (adj_en = 1, load = 0):
  - tick is ignored.
  - adj_step = 1 steps the adj_sel field by ±1 modulo its own modulus: up from MOD-1 goes to 0; down from 0 goes to MOD-1.
  - No carry or borrow into other fields. day_wrap = 0.
  - adj_sel = 3 or adj_step = 0: no change.
- Tick up (adj_en = 0, load = 0, tick = 1, up_down = 1):
  - sec increments.
  - If sec == MOD_S-1: sec -> 0 and min increments.
  - If min also == MOD_M-1: min -> 0 and hr increments.
  - If hr also == MOD_H-1: hr -> 0 and day_wrap = 1 for that one cycle.
- Tick down (up_down = 0): mirror of tick up.
  - sec == 0 -> MOD_S-1 with borrow into min.
  - min == 0 -> MOD_M-1 with borrow into hr.
  - hr == 0 on borrow -> MOD_H-1 and day_wrap = 1.
- Latency: all field updates and day_wrap are visible in the cycle after the triggering edge. No combinational path from inputs to outputs.
- day_wrap is 0 on every edge that does not cause a full rollover or underflow. Back-to-back ticks produce at most one pulse per wrap.
- tick = 0 and no other action: all outputs hold; day_wrap = 0.
- up_down is sampled on the same edge as tick or adj_step. Changing it between ticks has no other effect.
- Carry chain is purely combinational from the current field values (terminal-count detect per field, ANDed up the chain). No multi-cycle ripple: the whole cascade updates on a single edge.

Test Plan:
- Reset, then 3661 ticks up with 1-cycle gaps -> hr=1, min=1, sec=1, day_wrap never asserted.
- load (23, 59, 58), two ticks up -> (23, 59, 59), then (0, 0, 0) with day_wrap = 1 for exactly one cycle.
- load (0, 0, 0), one tick with up_down = 0 -> (23, 59, 59), day_wrap = 1 one cycle.
- load (5, 59, 59); adj_en = 1, adj_sel = 1, adj_step up -> (5, 0, 59), hours unchanged. Simultaneous tick is ignored. adj_sel = 2 with adj_step down from hr=0 -> hr = 23, no day_wrap.
- load with load_s = 63, load_m = 60, load_h = 30 -> (0, 0, 0). load and tick on the same edge -> load wins, no increment.
- Assert reset asynchronously mid-count at (12, 34, 56) between clock edges -> outputs (0, 0, 0) before the next edge. Counting resumes from (0, 0, 0, 1) on the first tick after release.
